// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the trained-weight readout path.
package nn_pkg;

  localparam int unsigned W_WIDTH        = 8;
  localparam int unsigned NN_NUM_WEIGHTS = 10;
  localparam logic [7:0]  RO_HDR_BYTE    = 8'hA5;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSnap = 3'd1,
    StHdr  = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4,
    StFin  = 3'd5
  } ro_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a registered
// one-cycle pulse on each low-to-high transition.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_pulse  <= r_sync & ~r_sync_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/weight_readout.sv
// Snapshots the trained weights and streams header, weight bytes and an XOR
// checksum to the host, one byte per host acknowledge.
module weight_readout
  import nn_pkg::*;
#(
  parameter int unsigned NUM_WEIGHTS = NN_NUM_WEIGHTS,
  parameter logic [7:0]  HDR_BYTE    = RO_HDR_BYTE
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           start_i,
  input  logic [NUM_WEIGHTS*W_WIDTH-1:0] weights_i,
  input  logic                           ack_i,
  input  logic                           abort_i,
  output logic [W_WIDTH-1:0]             data_o,
  output logic                           valid_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned   IdxW    = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_WEIGHTS - 1);

  ro_state_e                      r_state;
  ro_state_e                      w_state_d;
  logic [IdxW-1:0]                r_idx;
  logic [IdxW-1:0]                w_idx_d;
  logic [NUM_WEIGHTS*W_WIDTH-1:0] r_snap;
  logic [W_WIDTH-1:0]             r_csum;
  logic [W_WIDTH-1:0]             w_csum_snap;
  logic                           w_snap_load;
  logic                           r_start_q;
  logic                           w_start_rise;
  logic                           w_ack_evt;
  logic [W_WIDTH-1:0]             w_byte_d;
  logic [W_WIDTH-1:0]             r_data;
  logic [W_WIDTH-1:0]             w_data_d;
  logic                           r_valid;
  logic                           w_valid_d;
  logic                           r_busy;
  logic                           w_busy_d;
  logic                           r_done;
  logic                           w_done_d;

  sync_edge u_ack_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_async (ack_i),
    .o_pulse (w_ack_evt)
  );

  // start_i is already in the clk_i domain; a single flop gives the edge.
  assign w_start_rise = start_i & ~r_start_q;

  always_comb begin
    w_csum_snap = '0;
    for (int k = 0; k < NUM_WEIGHTS; k++) begin
      w_csum_snap = w_csum_snap ^ weights_i[k*W_WIDTH +: W_WIDTH];
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    if (abort_i) begin
      w_state_d = StIdle;
      w_idx_d   = '0;
    end else if (en_i) begin
      unique case (r_state)
        StIdle: begin
          if (w_start_rise) w_state_d = StSnap;
        end
        StSnap: w_state_d = StHdr;
        StHdr: begin
          if (w_ack_evt) begin
            w_state_d = StData;
            w_idx_d   = '0;
          end
        end
        StData: begin
          if (w_ack_evt) begin
            if (r_idx == IdxLast) w_state_d = StCsum;
            else                  w_idx_d   = r_idx + 1'b1;
          end
        end
        StCsum: begin
          if (w_ack_evt) w_state_d = StFin;
        end
        StFin: begin
          w_state_d = StIdle;
          w_idx_d   = '0;
        end
        default: begin
          w_state_d = StIdle;
          w_idx_d   = '0;
        end
      endcase
    end
  end

  assign w_snap_load = !abort_i && en_i && (r_state == StSnap);

  always_comb begin
    w_byte_d = '0;
    for (int k = 0; k < NUM_WEIGHTS; k++) begin
      if (w_idx_d == IdxW'(k)) w_byte_d = r_snap[k*W_WIDTH +: W_WIDTH];
    end
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    w_data_d  = '0;
    w_valid_d = 1'b0;
    w_done_d  = 1'b0;
    w_busy_d  = (w_state_d != StIdle);
    unique case (w_state_d)
      StHdr: begin
        w_data_d  = HDR_BYTE;
        w_valid_d = 1'b1;
      end
      StData: begin
        w_data_d  = w_byte_d;
        w_valid_d = 1'b1;
      end
      StCsum: begin
        w_data_d  = r_csum;
        w_valid_d = 1'b1;
      end
      StFin:   w_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_snap    <= '0;
      r_csum    <= '0;
      r_start_q <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_start_q <= start_i;
      r_data    <= w_data_d;
      r_valid   <= w_valid_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      if (w_snap_load) begin
        r_snap <= weights_i;
        r_csum <= w_csum_snap;
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule
